// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Holds state encodings, control polarity constants and the control bundle type.
package pipe_ctrl_pkg;

  localparam logic RESET   = 1'b1;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int unsigned MC_TIMEOUT_DEF   = 64;
  localparam int unsigned DRAIN_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MC_WAIT    = 2'd1,
    ST_TRAP_DRAIN = 2'd2,
    ST_TRAP_ENTER = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_hold;
    logic pc_load;
    logic if_id_refresh;
    logic id_ex_refresh;
    logic ex_mem_refresh;
    logic mem_wb_refresh;
    logic if_id_hold;
    logic id_ex_hold;
    logic ex_mem_hold;
    logic mem_wb_hold;
    logic irq_ack;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// Saturating up-counter with synchronous clear and enable.
// Shared by the multicycle timeout and the trap drain sequencing.
module pipe_ctrl_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rest,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i == ENABLE) begin
      cnt_d = '0;
    end else if (en_i == ENABLE && cnt_q != {W{1'b1}}) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rest == RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard controller: stage refresh/hold, PC redirect/hold, trap entry.
// Controls are decoded from the registered state and live inputs for the next edge.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WD           = 32,
  parameter int unsigned MC_TIMEOUT   = MC_TIMEOUT_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rest,
  input  logic          jump_flag_i,
  input  logic [WD-1:0] jump_addr_i,
  input  logic          load_use_i,
  input  logic          mc_start_i,
  input  logic          mc_done_i,
  input  logic          mem_wait_i,
  input  logic          irq_i,
  input  logic [WD-1:0] irq_vec_i,
  output logic          pc_hold_o,
  output logic          pc_load_o,
  output logic [WD-1:0] pc_load_addr_o,
  output logic          if_id_refresh_o,
  output logic          id_ex_refresh_o,
  output logic          ex_mem_refresh_o,
  output logic          mem_wb_refresh_o,
  output logic          if_id_hold_o,
  output logic          id_ex_hold_o,
  output logic          ex_mem_hold_o,
  output logic          mem_wb_hold_o,
  output logic          irq_ack_o,
  output logic          mc_timeout_o
);

  localparam int unsigned CW = $clog2(MC_TIMEOUT) + 1;

  state_e        state_q;
  state_e        state_d;
  logic          timeout_q;
  logic          timeout_d;
  logic          cnt_clr;
  logic          cnt_en;
  logic [CW-1:0] cnt;
  ctrl_t         ctrl;
  logic [WD-1:0] load_addr;

  pipe_ctrl_cnt #(
    .W (CW)
  ) u_cnt (
    .clk   (clk),
    .rest  (rest),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt)
  );

  // Priority: reset > mem wait > multicycle wait > jump > interrupt > load-use.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    cnt_clr   = DISABLE;
    cnt_en    = DISABLE;
    ctrl      = '0;
    load_addr = '0;

    if (rest == RESET) begin
      ctrl.if_id_refresh  = 1'b1;
      ctrl.id_ex_refresh  = 1'b1;
      ctrl.ex_mem_refresh = 1'b1;
      ctrl.mem_wb_refresh = 1'b1;
    end else if (mem_wait_i) begin
      ctrl.pc_hold     = 1'b1;
      ctrl.if_id_hold  = 1'b1;
      ctrl.id_ex_hold  = 1'b1;
      ctrl.ex_mem_hold = 1'b1;
      ctrl.mem_wb_hold = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (jump_flag_i) begin
            ctrl.pc_load       = 1'b1;
            ctrl.if_id_refresh = 1'b1;
            ctrl.id_ex_refresh = 1'b1;
            load_addr          = jump_addr_i;
          end else if (mc_start_i) begin
            state_d = ST_MC_WAIT;
            cnt_clr = ENABLE;
          end else if (irq_i) begin
            state_d = ST_TRAP_DRAIN;
            cnt_clr = ENABLE;
          end else if (load_use_i) begin
            ctrl.pc_hold       = 1'b1;
            ctrl.if_id_hold    = 1'b1;
            ctrl.id_ex_refresh = 1'b1;
          end
        end

        ST_MC_WAIT: begin
          if (mc_done_i) begin
            state_d = ST_RUN;
          end else begin
            ctrl.pc_hold        = 1'b1;
            ctrl.if_id_hold     = 1'b1;
            ctrl.id_ex_hold     = 1'b1;
            ctrl.ex_mem_refresh = 1'b1;
            cnt_en              = ENABLE;
            if (cnt == CW'(MC_TIMEOUT - 1)) begin
              timeout_d = 1'b1;
              state_d   = ST_RUN;
            end
          end
        end

        ST_TRAP_DRAIN: begin
          ctrl.pc_hold       = 1'b1;
          ctrl.if_id_refresh = 1'b1;
          ctrl.id_ex_refresh = 1'b1;
          cnt_en             = ENABLE;
          if (cnt == CW'(DRAIN_CYCLES - 1)) begin
            state_d = ST_TRAP_ENTER;
          end
        end

        ST_TRAP_ENTER: begin
          ctrl.pc_load       = 1'b1;
          ctrl.if_id_refresh = 1'b1;
          ctrl.irq_ack       = 1'b1;
          load_addr          = irq_vec_i;
          state_d            = ST_RUN;
        end

        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rest == RESET) begin
      state_q   <= ST_RUN;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  assign pc_hold_o        = ctrl.pc_hold;
  assign pc_load_o        = ctrl.pc_load;
  assign pc_load_addr_o   = load_addr;
  assign if_id_refresh_o  = ctrl.if_id_refresh;
  assign id_ex_refresh_o  = ctrl.id_ex_refresh;
  assign ex_mem_refresh_o = ctrl.ex_mem_refresh;
  assign mem_wb_refresh_o = ctrl.mem_wb_refresh;
  assign if_id_hold_o     = ctrl.if_id_hold;
  assign id_ex_hold_o     = ctrl.id_ex_hold;
  assign ex_mem_hold_o    = ctrl.ex_mem_hold;
  assign mem_wb_hold_o    = ctrl.mem_wb_hold;
  assign irq_ack_o        = ctrl.irq_ack;
  assign mc_timeout_o     = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with hand-computed control patterns.
// Control vector order: pc_hold pc_load rf_ifid rf_idex rf_exmem rf_memwb h_ifid h_idex h_exmem h_memwb ack tmo
module tb_pipe_ctrl;

  localparam int unsigned WD = 32;

  localparam logic [11:0] C_IDLE  = 12'b000000000000;
  localparam logic [11:0] C_RST   = 12'b001111000000;
  localparam logic [11:0] C_JUMP  = 12'b011100000000;
  localparam logic [11:0] C_LU    = 12'b100100100000;
  localparam logic [11:0] C_MCW   = 12'b100010110000;
  localparam logic [11:0] C_MEMW  = 12'b100000111100;
  localparam logic [11:0] C_DRAIN = 12'b101100000000;
  localparam logic [11:0] C_ENTER = 12'b011000000010;
  localparam logic [11:0] C_TMO   = 12'b000000000001;

  logic          clk = 1'b0;
  logic          rest;
  logic          jump_flag_i;
  logic [WD-1:0] jump_addr_i;
  logic          load_use_i;
  logic          mc_start_i;
  logic          mc_done_i;
  logic          mem_wait_i;
  logic          irq_i;
  logic [WD-1:0] irq_vec_i;
  logic          pc_hold_o;
  logic          pc_load_o;
  logic [WD-1:0] pc_load_addr_o;
  logic          if_id_refresh_o;
  logic          id_ex_refresh_o;
  logic          ex_mem_refresh_o;
  logic          mem_wb_refresh_o;
  logic          if_id_hold_o;
  logic          id_ex_hold_o;
  logic          ex_mem_hold_o;
  logic          mem_wb_hold_o;
  logic          irq_ack_o;
  logic          mc_timeout_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .WD (WD)
  ) dut (
    .clk              (clk),
    .rest             (rest),
    .jump_flag_i      (jump_flag_i),
    .jump_addr_i      (jump_addr_i),
    .load_use_i       (load_use_i),
    .mc_start_i       (mc_start_i),
    .mc_done_i        (mc_done_i),
    .mem_wait_i       (mem_wait_i),
    .irq_i            (irq_i),
    .irq_vec_i        (irq_vec_i),
    .pc_hold_o        (pc_hold_o),
    .pc_load_o        (pc_load_o),
    .pc_load_addr_o   (pc_load_addr_o),
    .if_id_refresh_o  (if_id_refresh_o),
    .id_ex_refresh_o  (id_ex_refresh_o),
    .ex_mem_refresh_o (ex_mem_refresh_o),
    .mem_wb_refresh_o (mem_wb_refresh_o),
    .if_id_hold_o     (if_id_hold_o),
    .id_ex_hold_o     (id_ex_hold_o),
    .ex_mem_hold_o    (ex_mem_hold_o),
    .mem_wb_hold_o    (mem_wb_hold_o),
    .irq_ack_o        (irq_ack_o),
    .mc_timeout_o     (mc_timeout_o)
  );

  logic [11:0] ctl;
  assign ctl = {pc_hold_o, pc_load_o, if_id_refresh_o, id_ex_refresh_o,
                ex_mem_refresh_o, mem_wb_refresh_o, if_id_hold_o, id_ex_hold_o,
                ex_mem_hold_o, mem_wb_hold_o, irq_ack_o, mc_timeout_o};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs are combinational, so sample shortly after inputs settle mid-cycle.
  task automatic expect_ctl(input string tag, input logic [11:0] exp_ctl,
                            input logic [WD-1:0] exp_addr);
    #1;
    check(tag, 32'(ctl), 32'(exp_ctl));
    check({tag, "_addr"}, pc_load_addr_o, exp_addr);
  endtask

  initial begin
    rest        = 1'b1;
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
    load_use_i  = 1'b0;
    mc_start_i  = 1'b0;
    mc_done_i   = 1'b0;
    mem_wait_i  = 1'b0;
    irq_i       = 1'b0;
    irq_vec_i   = '0;

    expect_ctl("reset0", C_RST, '0);
    tick();
    expect_ctl("reset1", C_RST, '0);
    tick();
    rest = 1'b0;
    expect_ctl("idle_after_reset", C_IDLE, '0);
    tick();

    // Jump redirect, zero penalty.
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0100;
    expect_ctl("jump", C_JUMP, 32'h0000_0100);
    tick();
    jump_flag_i = 1'b0;
    expect_ctl("jump_after", C_IDLE, '0);
    tick();

    // Single load-use bubble.
    load_use_i = 1'b1;
    expect_ctl("load_use", C_LU, '0);
    tick();
    load_use_i = 1'b0;
    expect_ctl("load_use_after", C_IDLE, '0);
    tick();

    // Multicycle op, done at t0+5.
    mc_start_i = 1'b1;
    expect_ctl("mc_start", C_IDLE, '0);
    tick();
    mc_start_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect_ctl($sformatf("mc_wait%0d", i), C_MCW, '0);
      tick();
    end
    mc_done_i = 1'b1;
    expect_ctl("mc_done", C_IDLE, '0);
    tick();
    mc_done_i = 1'b0;
    expect_ctl("mc_back_run", C_IDLE, '0);
    tick();

    // Data-bus wait overriding a pending multicycle release.
    mc_start_i = 1'b1;
    #1;
    tick();
    mc_start_i = 1'b0;
    expect_ctl("mcw_pre_memwait", C_MCW, '0);
    tick();
    mem_wait_i = 1'b1;
    mc_done_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_ctl($sformatf("mem_wait%0d", i), C_MEMW, '0);
      tick();
    end
    mem_wait_i = 1'b0;
    expect_ctl("mem_wait_release", C_IDLE, '0);
    tick();
    mc_done_i = 1'b0;
    expect_ctl("mem_wait_run", C_IDLE, '0);
    tick();

    // Interrupt entry; irq drops during drain.
    irq_i     = 1'b1;
    irq_vec_i = 32'h0000_0800;
    expect_ctl("irq_take", C_IDLE, '0);
    tick();
    irq_i = 1'b0;
    expect_ctl("drain0", C_DRAIN, '0);
    tick();
    expect_ctl("drain1", C_DRAIN, '0);
    tick();
    expect_ctl("trap_enter", C_ENTER, 32'h0000_0800);
    tick();
    expect_ctl("trap_after", C_IDLE, '0);
    tick();

    // Jump beats irq and load-use; irq taken the following cycle.
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0200;
    load_use_i  = 1'b1;
    irq_i       = 1'b1;
    expect_ctl("combo_jump", C_JUMP, 32'h0000_0200);
    tick();
    jump_flag_i = 1'b0;
    load_use_i  = 1'b0;
    expect_ctl("combo_irq_take", C_IDLE, '0);
    tick();
    irq_i = 1'b0;
    expect_ctl("combo_drain0", C_DRAIN, '0);
    tick();
    expect_ctl("combo_drain1", C_DRAIN, '0);
    tick();
    expect_ctl("combo_enter", C_ENTER, 32'h0000_0800);
    tick();

    // Multicycle timeout without done.
    mc_start_i = 1'b1;
    expect_ctl("tmo_start", C_IDLE, '0);
    tick();
    mc_start_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      expect_ctl($sformatf("tmo_wait%0d", i), C_MCW, '0);
      tick();
    end
    expect_ctl("tmo_sticky", C_TMO, '0);
    tick();
    load_use_i = 1'b1;
    expect_ctl("tmo_run_lu", C_LU | C_TMO, '0);
    tick();
    load_use_i = 1'b0;

    // Reset in the middle of MC_WAIT.
    mc_start_i = 1'b1;
    #1;
    tick();
    mc_start_i = 1'b0;
    expect_ctl("mid_mcw", C_MCW | C_TMO, '0);
    tick();
    rest = 1'b1;
    expect_ctl("mid_reset", C_RST | C_TMO, '0);
    tick();
    rest = 1'b0;
    expect_ctl("post_reset", C_IDLE, '0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
